// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - conv weight-memory load sequencer (kernel, bias, coeff regions)
//
// Accepts a 32-bit valid/ready word stream and turns each accepted word into one
// write on the conv weight-write port. Regions load in fixed order kernel -> bias
// -> MACC coeff; a region with a zero count is skipped.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   pulse: begin a load (honoured in IDLE or DONE only)
//   abort          in   pulse: cancel load, back to IDLE (wins over start)
//   s_data         in   weight word
//   s_valid        in   s_data valid
//   s_ready        out  word accepted this cycle when s_valid is high
//   weight_wr_data out  registered write data
//   weight_wr_addr out  registered write address (region base + index)
//   weight_wr_en   out  write strobe, one cycle after each transfer
//   busy           out  a region is being loaded
//   load_done      out  all regions written; held until next start/abort
//   region         out  0 idle/done, 1 kernel, 2 bias, 3 coeff
module weight_load_ctrl #(
  parameter int unsigned NUM_KERNEL           = 81,
  parameter int unsigned NUM_BIAS             = 3,
  parameter int unsigned NUM_MACC_COEFF       = 1,
  parameter logic [31:0] KERNEL_BASE_ADDR     = 32'd0,
  parameter logic [31:0] BIAS_BASE_ADDR       = 32'd81,
  parameter logic [31:0] MACC_COEFF_BASE_ADDR = 32'd84
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] weight_wr_data,
  output logic [31:0] weight_wr_addr,
  output logic        weight_wr_en,
  output logic        busy,
  output logic        load_done,
  output logic [1:0]  region
);

  // One shared index sized for the largest region keeps the datapath single.
  localparam int unsigned MAX_KB  = (NUM_KERNEL > NUM_BIAS) ? NUM_KERNEL : NUM_BIAS;
  localparam int unsigned MAX_ALL = (MAX_KB > NUM_MACC_COEFF) ? MAX_KB : NUM_MACC_COEFF;
  localparam int unsigned MAX_CNT = (MAX_ALL > 0) ? MAX_ALL : 1;
  localparam int          IW      = $clog2(MAX_CNT + 1);

  localparam logic [IW-1:0] CNT_K = IW'(NUM_KERNEL);
  localparam logic [IW-1:0] CNT_B = IW'(NUM_BIAS);
  localparam logic [IW-1:0] CNT_C = IW'(NUM_MACC_COEFF);

  typedef enum logic [2:0] {
    IDLE,
    KERN,
    BIAS,
    COEF,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic [IW-1:0] cur_cnt;
  logic [31:0]   cur_base;
  logic          xfer;
  logic          last;

  // Successor of a finished region, skipping empty regions further down the order.
  function automatic state_t after_bias();
    if (NUM_MACC_COEFF != 0) return COEF;
    return DONE;
  endfunction

  function automatic state_t after_kern();
    if (NUM_BIAS != 0) return BIAS;
    return after_bias();
  endfunction

  function automatic state_t first_region();
    if (NUM_KERNEL != 0) return KERN;
    return after_kern();
  endfunction

  function automatic logic [1:0] encode(input state_t s);
    case (s)
      KERN:    return 2'd1;
      BIAS:    return 2'd2;
      COEF:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign s_ready = (state == KERN) || (state == BIAS) || (state == COEF);
  assign busy    = s_ready;
  assign xfer    = s_valid & s_ready;

  always_comb begin
    cur_cnt    = '0;
    cur_base   = '0;
    state_next = state;
    case (state)
      KERN: begin
        cur_cnt  = CNT_K;
        cur_base = KERNEL_BASE_ADDR;
      end
      BIAS: begin
        cur_cnt  = CNT_B;
        cur_base = BIAS_BASE_ADDR;
      end
      COEF: begin
        cur_cnt  = CNT_C;
        cur_base = MACC_COEFF_BASE_ADDR;
      end
      default: ;
    endcase

    last = xfer && (idx == cur_cnt - IW'(1));

    case (state)
      IDLE, DONE: if (start) state_next = first_region();
      KERN:       if (last)  state_next = after_kern();
      BIAS:       if (last)  state_next = after_bias();
      COEF:       if (last)  state_next = DONE;
      default:    state_next = IDLE;
    endcase

    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      weight_wr_en   <= 1'b0;
      weight_wr_addr <= '0;
      weight_wr_data <= '0;
      load_done      <= 1'b0;
      region         <= 2'd0;
    end else begin
      state        <= state_next;
      // A transfer in the abort cycle was already handshaken, so its write still issues.
      weight_wr_en <= xfer;
      if (xfer) begin
        weight_wr_addr <= cur_base + 32'(idx);
        weight_wr_data <= s_data;
      end
      // Every state change is a region entry (or exit), so the index restarts there.
      if (state_next != state) begin
        idx <= '0;
      end else if (xfer) begin
        idx <= idx + IW'(1);
      end
      load_done <= (state_next == DONE);
      region    <= encode(state_next);
    end
  end

endmodule
